// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I load/store funct3 encodings, LSU state codes and access-size helpers
package riscv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_DONE = 2'd2;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} lsu_size_e;
  // reserved encodings (011, 110, 111) fall through to word
  function automatic lsu_size_e size_of(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? SZ_B : f3[1:0] == 2'b01 ? SZ_H : SZ_W;
  endfunction
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return size_of(f3) == SZ_B ? 1'b0 : size_of(f3) == SZ_H ? off[0] : |off;
  endfunction
endpackage

// File: rtl/m_lsu_if.sv
// m_lsu_if: data-memory req/ack port between the LSU (master) and memory (slave)
interface m_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  modport master(output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, input dmem_ack, dmem_rdata);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, output dmem_ack, dmem_rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/byte enables and load lane select with sign/zero extension
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] ld_data
);
  lsu_size_e   sz;
  logic        sx;
  logic [7:0]  b;
  logic [15:0] h;
  // halfwords pick their lane by off[1] only, words ignore off entirely
  always_comb begin
    sz      = size_of(funct3);
    sx      = ~funct3[2];
    b       = rd_word[{off, 3'b000} +: 8];
    h       = off[1] ? rd_word[31:16] : rd_word[15:0];
    be      = sz == SZ_B ? 4'b0001 << off : sz == SZ_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata   = sz == SZ_B ? {4{st_data[7:0]}} : sz == SZ_H ? {2{st_data[15:0]}} : st_data;
    ld_data = sz == SZ_B ? {{24{sx & b[7]}}, b} : sz == SZ_H ? {{16{sx & h[15]}}, h} : rd_word;
  end
endmodule

// File: rtl/m_lsu.sv
// m_lsu: memory-stage load/store unit; optional misaligned-access trap under LSU_MISALIGN_TRAP_EN
module m_lsu
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren_M,
  input  logic        mem_wen_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] alu_result_M,
  input  logic [31:0] rs2_data_M,
  m_lsu_if.master     dmem,
  output logic [31:0] mem_rdata_M,
  output logic        lsu_stall
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_M
`endif
);
  logic [1:0]  state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        access, in_req;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [31:0] al_wdata, al_ldata;
  logic [3:0]  al_be;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
  assign misalign_M = mis_q;
`endif
  assign access = mem_ren_M | mem_wen_M;
  assign in_req = state_q == LSU_REQ;
  // while waiting for ack the pipeline is frozen, but the latched funct3/offset are used for extension
  assign al_f3  = in_req ? f3_q : funct3_M;
  assign al_off = in_req ? off_q : alu_result_M[1:0];
  lsu_align u_align (
    .funct3  (al_f3),
    .off     (al_off),
    .st_data (rs2_data_M),
    .rd_word (dmem.dmem_rdata),
    .wdata   (al_wdata),
    .be      (al_be),
    .ld_data (al_ldata)
  );
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;
  assign mem_rdata_M     = rdata_q;
  assign lsu_stall       = rst_n & ((state_q == LSU_IDLE & access) | in_req);
  // next-state and bus register computation; bus outputs hold until the next access is launched
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    if (state_q == LSU_IDLE && access) begin
`ifdef LSU_MISALIGN_TRAP_EN
      if (is_misaligned(funct3_M, alu_result_M[1:0])) begin
        state_d = LSU_DONE;
        mis_d   = 1'b1;
        rdata_d = '0;
      end else
`endif
      begin
        state_d = LSU_REQ;
        req_d   = 1'b1;
        we_d    = mem_wen_M;
        addr_d  = {alu_result_M[31:2], 2'b00};
        wdata_d = al_wdata;
        be_d    = al_be;
        f3_d    = funct3_M;
        off_d   = alu_result_M[1:0];
      end
    end else if (in_req && dmem.dmem_ack) begin
      state_d = LSU_DONE;
      req_d   = 1'b0;
      rdata_d = we_q ? rdata_q : al_ldata;
    end else if (state_q == LSU_DONE) begin
      state_d = LSU_IDLE;
    end
  end
  // state and bus registers, cleared asynchronously even mid-transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end
endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: directed self-checking bench for m_lsu with a spec-level expectation model
module tb_m_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ren_M = 1'b0, mem_wen_M = 1'b0;
  logic [2:0]  funct3_M = 3'b000;
  logic [31:0] alu_result_M = '0, rs2_data_M = '0;
  logic [31:0] mem_rdata_M;
  logic        lsu_stall;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_M;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  m_lsu_if dmem();
  always #5 clk = ~clk;
  m_lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_ren_M    (mem_ren_M),
    .mem_wen_M    (mem_wen_M),
    .funct3_M     (funct3_M),
    .alu_result_M (alu_result_M),
    .rs2_data_M   (rs2_data_M),
    .dmem         (dmem),
    .mem_rdata_M  (mem_rdata_M),
    .lsu_stall    (lsu_stall)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_M   (misalign_M)
`endif
  );
  int checks = 0, passed = 0;
  logic        chk_en = 1'b0;
  logic        e_stall = 1'b0, e_req = 1'b0, e_we = 1'b0, e_mis = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, model_rdata = '0;
  logic [3:0]  e_be = '0;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  int          stall_cnt;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  // access width in bytes from funct3; reserved codes are word accesses
  function automatic int sz(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
  endfunction
  function automatic int lane(input logic [2:0] f3, input logic [31:0] a);
    return int'(a[1:0]) / sz(f3) * sz(f3);
  endfunction
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    m = 4'((1 << sz(f3)) - 1);
    return m << lane(f3, a);
  endfunction
  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    return sz(f3) == 1 ? {24'd0, d[7:0]} * 32'h01010101 : sz(f3) == 2 ? {16'd0, d[15:0]} * 32'h00010001 : d;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int n;
    logic [31:0] v;
    n = sz(f3);
    v = w >> (8 * lane(f3, a));
    if (n < 4) begin
      v = v & ((32'd1 << (8 * n)) - 32'd1);
      if (!f3[2] && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    end
    return v;
  endfunction
  // single compare process: every cycle, DUT outputs against the model expectations
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(lsu_stall), 32'(e_stall));
      chk("req", 32'(dmem.dmem_req), 32'(e_req));
      chk("rdata_M", mem_rdata_M, model_rdata);
      if (e_req) begin
        chk("we", 32'(dmem.dmem_we), 32'(e_we));
        chk("addr", dmem.dmem_addr, e_addr);
        chk("be", 32'(dmem.dmem_be), 32'(e_be));
        if (e_we) chk("wdata", dmem.dmem_wdata, e_wdata);
      end
`ifdef LSU_MISALIGN_TRAP_EN
      chk("misalign", 32'(misalign_M), 32'(e_mis));
`endif
    end
  end
  task automatic step();
    #1;
    if (lsu_stall) stall_cnt++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) begin
      e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0;
      dmem.dmem_ack = ack; dmem.dmem_rdata = 32'hFFFFFFFF;
      step();
    end
    dmem.dmem_ack = 1'b0;
  endtask
  task automatic access(input logic ren, input logic wen, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int k, input logic [31:0] w);
    logic mis;
    mis = TRAP && (int'(a[1:0]) % sz(f3) != 0);
    stall_cnt = 0;
    mem_ren_M = ren; mem_wen_M = wen; funct3_M = f3; alu_result_M = a; rs2_data_M = d;
    e_stall = 1'b1; e_req = 1'b0; e_mis = 1'b0;
    step();
    if (!mis) begin
      for (int j = 1; j <= k; j++) begin
        e_req = 1'b1; e_stall = 1'b1; e_we = wen;
        e_addr = a & ~32'd3; e_be = m_be(f3, a); e_wdata = m_wdata(f3, d);
        dmem.dmem_ack = (j == k);
        dmem.dmem_rdata = (j == k) ? w : 32'h5A5A5A5A;
        cap_we = dmem.dmem_we; cap_addr = dmem.dmem_addr; cap_wdata = dmem.dmem_wdata; cap_be = dmem.dmem_be;
        step();
      end
    end
    dmem.dmem_ack = 1'b0;
    e_req = 1'b0; e_stall = 1'b0; e_mis = mis;
    if (mis) model_rdata = '0;
    else if (!wen) model_rdata = m_load(f3, a, w);
    step();
    mem_ren_M = 1'b0; mem_wen_M = 1'b0;
    e_mis = 1'b0;
  endtask
  initial begin
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem.dmem_req), 32'd0);
    chk("rst_rdata", mem_rdata_M, 32'd0);
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2, 1'b0);
    access(1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    chk("lw_rdata", mem_rdata_M, 32'hDEADBEEF);
    chk("lw_addr", cap_addr, 32'h100);
    chk("lw_be", 32'(cap_be), 32'hF);
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
    access(1, 0, 3'b000, 32'h103, 32'h0, 2, 32'h80112233);
    chk("lb_rdata", mem_rdata_M, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);
    chk("lbu_rdata", mem_rdata_M, 32'h00000080);
    access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'h0);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(cap_we), 32'd1);
    chk("sh_rdata_kept", mem_rdata_M, 32'h00000080);
    chk("sh_stall_cycles", 32'(stall_cnt), 32'd2);
    access(1, 0, 3'b010, 32'h10, 32'h0, 1, 32'h11111111);
    chk("b2b_first", mem_rdata_M, 32'h11111111);
    access(1, 0, 3'b010, 32'h14, 32'h0, 1, 32'h22222222);
    chk("b2b_second", mem_rdata_M, 32'h22222222);
    access(1, 0, 3'b001, 32'h106, 32'h0, 2, 32'h80011234);
    chk("lh_rdata", mem_rdata_M, 32'hFFFF8001);
    access(1, 0, 3'b101, 32'h104, 32'h0, 1, 32'h80011234);
    chk("lhu_rdata", mem_rdata_M, 32'h00001234);
    access(0, 1, 3'b000, 32'h101, 32'h123456EF, 2, 32'h0);
    chk("sb_be", 32'(cap_be), 32'h2);
    chk("sb_wdata", cap_wdata, 32'hEFEFEFEF);
    access(1, 1, 3'b010, 32'h300, 32'hCAFEBABE, 1, 32'h99999999);
    chk("ren_wen_is_store", 32'(cap_we), 32'd1);
    chk("ren_wen_rdata_kept", mem_rdata_M, 32'h00001234);
    access(1, 0, 3'b011, 32'h104, 32'h0, 1, 32'h87654321);
    chk("reserved_is_word", mem_rdata_M, 32'h87654321);
    idle(3, 1'b1);
    access(1, 0, 3'b010, 32'h101, 32'h0, 2, 32'h0BADF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_rdata_zero", mem_rdata_M, 32'h0);
    chk("mis_stall_cycles", 32'(stall_cnt), 32'd1);
`else
    chk("mis_addr_aligned", cap_addr, 32'h100);
    chk("mis_rdata_word", mem_rdata_M, 32'h0BADF00D);
`endif
    idle(1, 1'b0);
    chk_en = 1'b0;
    mem_ren_M = 1'b1; funct3_M = 3'b010; alu_result_M = 32'h400;
    @(posedge clk);
    #1;
    chk("pre_rst_req", 32'(dmem.dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(dmem.dmem_req), 32'd0);
    chk("async_rst_we", 32'(dmem.dmem_we), 32'd0);
    chk("async_rst_addr", dmem.dmem_addr, 32'd0);
    chk("async_rst_wdata", dmem.dmem_wdata, 32'd0);
    chk("async_rst_be", 32'(dmem.dmem_be), 32'd0);
    chk("async_rst_rdata", mem_rdata_M, 32'd0);
    chk("async_rst_stall", 32'(lsu_stall), 32'd0);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    mem_ren_M = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("late_ack_req", 32'(dmem.dmem_req), 32'd0);
    chk("late_ack_rdata", mem_rdata_M, 32'd0);
    dmem.dmem_ack = 1'b0;
    model_rdata = '0;
    e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0;
    chk_en = 1'b1;
    idle(1, 1'b0);
    access(1, 0, 3'b000, 32'h502, 32'h0, 1, 32'h00C30000);
    chk("post_rst_lb", mem_rdata_M, 32'hFFFFFFC3);
    idle(2, 1'b0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/m_lsu.md
# m_lsu

Memory-stage load/store unit. Sits between the E/M pipeline register and the M/RB register: it takes the address (ALU result), store data and funct3 of the instruction in M, runs a req/ack transaction on the data-memory port, and produces the aligned, sign/zero-extended `mem_rdata_M` that M/RB captures. It stalls the pipeline while a transaction is outstanding.

## Interface
Parameters:
- none (data path fixed at 32 bits, RV32I).

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `mem_ren_M`  in  1  instruction in M is a load
- `mem_wen_M`  in  1  instruction in M is a store
- `funct3_M`  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- `alu_result_M`  in  32  byte address
- `rs2_data_M`  in  32  store data (unaligned, in low bits)
- `dmem_req`  out  1  transaction request, registered
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  32  word address (`addr[31:2]`, low two bits 0)
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_be`  out  4  byte enables
- `dmem_ack`  in  1  memory completes transaction this cycle
- `dmem_rdata`  in  32  read word, valid when `dmem_ack`=1
- `mem_rdata_M`  out  32  extended load result, registered
- `lsu_stall`  out  1  hold IF..M stages this cycle
- `misalign_M`  out  1  misaligned access flag (only with `LSU_MISALIGN_TRAP_EN`)

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: if `mem_ren_M|mem_wen_M` → register addr/we/wdata/be, go REQ. Else stay.
- REQ: `dmem_req`=1, all `dmem_*` outputs held stable until `dmem_ack`. On ack: loads capture extended `dmem_rdata` into `mem_rdata_M`; go DONE.
- DONE: one cycle, stall released so the pipeline advances; unconditionally → IDLE.
- `lsu_stall` = `rst_n & ((IDLE & access) | REQ)`; 0 in DONE.
- `ren` and `wen` both high: treated as store.
- Store alignment: SB `be`=1<<addr[1:0], byte replicated ×4; SH `be`=0011/1100 by addr[1], half replicated ×2; SW `be`=1111.
- Load extension: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend; reserved funct3 (011,110,111) treated as W.
- Stores leave `mem_rdata_M` unchanged.
- Reset (async, incl. mid-transaction): state IDLE; `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be`, `mem_rdata_M`, `misalign_M` all 0; stall 0. The memory must tolerate request withdrawal.

## Timing
- Access seen in IDLE at cycle n → `dmem_req` high at n+1 → ack at n+k (k≥1) → DONE and `mem_rdata_M` valid at n+k+1; M/RB captures at end of n+k+1. Minimum 3 cycles per access, stall high for k+1 cycles.
- Ack in the same cycle `dmem_req` first rises is legal (k=1).
- `dmem_ack` outside REQ is ignored.
- Back-to-back accesses: second one's IDLE cycle immediately follows DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issue no transaction; FSM goes IDLE→DONE, `misalign_M`=1 for that DONE cycle, `mem_rdata_M`=0, stall high only in the IDLE cycle.
- Undefined: `misalign_M` port absent; offending low address bits ignored (H uses addr[1], W uses none); access proceeds normally.

## Structure
- Shared package `riscv_pkg`: funct3 load/store encodings, LSU state enum.
- One sub-module `lsu_align`: combinational store lane/byte-enable generation and load lane select + extension; FSM and registers stay in `m_lsu`.

## Test plan
- LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF → `dmem_addr`=0x100, be=1111, `mem_rdata_M`=0xDEADBEEF in DONE, stall high 4 cycles.
- LB addr 0x103, rdata 0x80112233 → `mem_rdata_M`=0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x202, rs2=0x0000ABCD, ack next cycle → be=1100, wdata=0xABCDABCD, we=1, `mem_rdata_M` unchanged.
- Two back-to-back LWs with immediate ack → each completes in 3 cycles, no lost/duplicated request.
- rst_n low while in REQ → `dmem_req`=0 at once, state IDLE, all outputs 0; late ack ignored.
- With macro, LW addr 0x101 → no `dmem_req`, `misalign_M`=1 one cycle; without macro → `dmem_addr`=0x100, normal load.
